// File: rtl/ram_fifo_pkg.sv
// Shared defaults and type definitions for the single-port-RAM FIFO controller.
// Imported by the interface, the arbiter and the top.
package ram_fifo_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    // Which side wins when push and pop are both eligible in the same cycle.
    typedef enum logic {
        PRIO_POP  = 1'b0,
        PRIO_PUSH = 1'b1
    } prio_e;

    typedef struct packed {
        logic push;
        logic pop;
    } grant_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle of the FIFO controller.
// The master side is the producer/consumer environment; the slave side is the FIFO.
interface ram_fifo_ctrl_if
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_req;
    logic              pop_ready;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_ready, pop_valid, pop_data
    );

endinterface

// File: rtl/ram_fifo_ctrl_arbiter.sv
// Grants at most one side per cycle to the single RAM port.
// A contested cycle goes to the side named by prio, and prio then flips.
module fifo_arbiter
    import ram_fifo_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push_elig,
    input  logic   i_pop_elig,
    output grant_t o_grant
);

    prio_e r_prio;
    prio_e w_prio_next;
    logic  w_contested;

    assign w_contested = i_push_elig & i_pop_elig;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= PRIO_POP;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // NOTE: assigning a default first in every always_comb path prevents latch inference.
    always_comb begin
        w_prio_next = r_prio;
        if (w_contested) begin
            w_prio_next = (r_prio == PRIO_POP) ? PRIO_PUSH : PRIO_POP;
        end
    end

    // Grants are held low during reset so no RAM access starts in a reset cycle.
    always_comb begin
        o_grant = '0;
        if (!reset) begin
            if (w_contested) begin
                o_grant.push = (r_prio == PRIO_PUSH);
                o_grant.pop  = (r_prio == PRIO_POP);
            end else begin
                o_grant.push = i_push_elig;
                o_grant.pop  = i_pop_elig;
            end
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external single-port RAM with registered read data.
// Holds the pointers, the occupancy count and the RAM port; arbitration lives in fifo_arbiter.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    ram_fifo_ctrl_if.slave     fifo_if,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W:0]    count,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wr_data,
    output logic               ram_write_en,
    input  logic [DATA_W-1:0]  ram_rd_data
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_pop_valid;

    logic   w_push_elig;
    logic   w_pop_elig;
    grant_t w_grant;

    // Full and empty come from the count only, so wrapped pointers never alias.
    assign full        = (r_count == DEPTH_CNT);
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign w_push_elig = fifo_if.push_valid & ~full;
    assign w_pop_elig  = fifo_if.pop_req & ~empty;

    fifo_arbiter u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .i_push_elig (w_push_elig),
        .i_pop_elig  (w_pop_elig),
        .o_grant     (w_grant)
    );

    assign fifo_if.push_ready = w_grant.push;
    assign fifo_if.pop_ready  = w_grant.pop;
    assign fifo_if.pop_valid  = r_pop_valid;
    assign fifo_if.pop_data   = ram_rd_data;

    assign ram_write_en = w_grant.push;
    assign ram_addr     = w_grant.push ? r_wr_ptr : r_rd_ptr;
    assign ram_wr_data  = fifo_if.push_data;

    // NOTE: only control state is reset; RAM contents are external and stay as they were.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_grant.pop;
            if (w_grant.push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + ADDR_W'(1);
                r_count  <= r_count + (ADDR_W + 1)'(1);
            end
            if (w_grant.pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + ADDR_W'(1);
                r_count  <= r_count - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed and random steps compared against
// a queue-based FIFO model, with a behavioural single-port RAM attached to the DUT.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_W(DW)) fifo_if ();

    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_write_en;
    logic [DW-1:0] ram_rd_data;

    ram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_if      (fifo_if.slave),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .ram_addr     (ram_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_write_en (ram_write_en),
        .ram_rd_data  (ram_rd_data)
    );

    // External single-port RAM: registered read, no read in a write cycle.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_wr_data;
        else              ram_rd_data   <= mem[ram_addr];
    end

    // Reference model state.
    logic [DW-1:0] q[$];
    int            m_wr;
    int            m_rd;
    bit            m_prio;
    bit            m_pv_exp;
    logic [DW-1:0] m_pdata_exp;
    bit            m_known;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, check 1 ns later,
    // advance the model, then wait for the next falling edge.
    task automatic step(input bit rst, input bit pv, input logic [DW-1:0] pd, input bit pr);
        bit pe;
        bit oe;
        bit g_push;
        bit g_pop;
        reset              = rst;
        fifo_if.push_valid = pv;
        fifo_if.push_data  = pd;
        fifo_if.pop_req    = pr;
        #1;
        pe     = pv && (q.size() < DEPTH);
        oe     = pr && (q.size() > 0);
        g_push = 1'b0;
        g_pop  = 1'b0;
        if (!rst) begin
            if (pe && oe) begin
                g_push = m_prio;
                g_pop  = !m_prio;
            end else begin
                g_push = pe;
                g_pop  = oe;
            end
        end

        check("push_ready", {31'd0, fifo_if.push_ready}, {31'd0, g_push});
        check("pop_ready", {31'd0, fifo_if.pop_ready}, {31'd0, g_pop});
        check("ram_write_en", {31'd0, ram_write_en}, {31'd0, g_push});
        if (g_push) check("ram_wr_data", {24'd0, ram_wr_data}, {24'd0, pd});
        if (m_known) begin
            check("ram_addr", {24'd0, ram_addr}, g_push ? m_wr : m_rd);
            check("count", {23'd0, count}, q.size());
            check("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
            check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
            check("pop_valid", {31'd0, fifo_if.pop_valid}, {31'd0, m_pv_exp});
            if (m_pv_exp) check("pop_data", {24'd0, fifo_if.pop_data}, {24'd0, m_pdata_exp});
        end

        if (rst) begin
            q.delete();
            m_wr     = 0;
            m_rd     = 0;
            m_prio   = 1'b0;
            m_pv_exp = 1'b0;
            m_known  = 1'b1;
        end else begin
            if (g_push) begin
                q.push_back(pd);
                m_wr = (m_wr + 1) % DEPTH;
            end
            m_pv_exp = g_pop;
            if (g_pop) begin
                m_pdata_exp = q.pop_front();
                m_rd        = (m_rd + 1) % DEPTH;
            end
            if (pe && oe) m_prio = !m_prio;
        end
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'($urandom_range(0, 255));
    endfunction

    initial begin
        m_known            = 1'b0;
        m_pv_exp           = 1'b0;
        m_prio             = 1'b0;
        m_wr               = 0;
        m_rd               = 0;
        m_pdata_exp        = '0;
        reset              = 1'b1;
        fifo_if.push_valid = 1'b0;
        fifo_if.push_data  = '0;
        fifo_if.pop_req    = 1'b0;
        @(negedge clk);

        step(1, 0, '0, 0);
        step(1, 0, '0, 0);

        // Pop requests on an empty FIFO are ignored.
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Three pushes then three back-to-back pops.
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Entry pushed in one cycle is poppable in the next.
        step(0, 1, 8'h5C, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Fill from a clean reset, overflow attempt, wrap-around push, full drain.
        step(1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, rnd_data(), 0);
        step(0, 1, rnd_data(), 0);
        step(0, 0, '0, 1);
        step(0, 1, 8'hAA, 0);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Contested cycles starting from a single stored entry.
        step(0, 1, rnd_data(), 0);
        for (int i = 0; i < 10; i++) step(0, 1, rnd_data(), 1);
        step(0, 0, '0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), bit'($urandom_range(0, 1)), rnd_data(),
                 bit'($urandom_range(0, 1)));
        end

        // Reset right after a pop grant discards the outstanding read.
        step(1, 0, '0, 0);
        step(0, 1, rnd_data(), 0);
        step(0, 1, rnd_data(), 0);
        step(0, 0, '0, 1);
        step(1, 0, '0, 0);
        step(0, 1, rnd_data(), 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
